// File: rtl/flit_mux_if.sv
// ---------------------------------------------------------------------------
// flit_mux_if
// Bundle of the flit_mux data-path signals: two input flit ports, the one-hot
// port select, and the single output flit port.
//
// Flow control: valid-only. A flit is transferred in every cycle where its
// valid bit is 1. There is no ready signal, so the consumer of
// odata/ovalid/ovch must accept every flit presented with ovalid = 1.
//
// Signals
//   idata_0 / ivalid_0 / ivch_0  flit, valid, VC id from input port 0
//   idata_1 / ivalid_1 / ivch_1  flit, valid, VC id from input port 1
//   sel                          one-hot port select (only bits [1:0] decoded)
//   odata / ovalid / ovch        selected flit, valid, VC id
//
// Modports
//   master  traffic source/sink side (drives inputs and sel, observes outputs)
//   slave   the multiplexer itself
// ---------------------------------------------------------------------------
interface flit_mux_if #(
  parameter int DATA_W = 67,
  parameter int VCH_W  = 1,
  parameter int SEL_W  = 5
);
  logic [DATA_W-1:0] idata_0;
  logic              ivalid_0;
  logic [VCH_W-1:0]  ivch_0;
  logic [DATA_W-1:0] idata_1;
  logic              ivalid_1;
  logic [VCH_W-1:0]  ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;

  modport master (
    output idata_0, ivalid_0, ivch_0,
    output idata_1, ivalid_1, ivch_1,
    output sel,
    input  odata, ovalid, ovch
  );

  modport slave (
    input  idata_0, ivalid_0, ivch_0,
    input  idata_1, ivalid_1, ivch_1,
    input  sel,
    output odata, ovalid, ovch
  );
endinterface

// File: rtl/flit_mux.sv
// ---------------------------------------------------------------------------
// flit_mux
// Two-input flit multiplexer for the router crossbar/output stage. The one-hot
// select picks port 0 or port 1 and the whole flit tuple (data, valid, VC id)
// of that port is forwarded unmodified. Optional output register.
//
// Ports
//   clk  rising-edge clock (unused when REG_OUT = 0)
//   rst  asynchronous active-high reset, clears the output register
//        (unused when REG_OUT = 0)
//   fm   flit_mux_if.slave: idata_*/ivalid_*/ivch_* in, sel in,
//        odata/ovalid/ovch out
//
// Parameters
//   DATA_W   flit width (top 3 bits carry the flit type, rest payload)
//   VCH_W    VC id width
//   SEL_W    select width; only sel[1:0] is decoded
//   REG_OUT  1 = registered outputs, 1-cycle latency; 0 = combinational
// ---------------------------------------------------------------------------
module flit_mux #(
  parameter int DATA_W  = 67,
  parameter int VCH_W   = 1,
  parameter int SEL_W   = 5,
  parameter bit REG_OUT = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  flit_mux_if.slave fm
);

  logic [DATA_W-1:0] mux_data;
  logic              mux_valid;
  logic [VCH_W-1:0]  mux_vch;

  // Whole-tuple select: each arm takes all three fields from one port so
  // fields of different ports can never be mixed. None-hot and multi-hot
  // selects forward an all-zero, invalid flit rather than X.
  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    mux_vch   = '0;
    case (fm.sel[1:0])
      2'b01: begin
        mux_data  = fm.idata_0;
        mux_valid = fm.ivalid_0;
        mux_vch   = fm.ivch_0;
      end
      2'b10: begin
        mux_data  = fm.idata_1;
        mux_valid = fm.ivalid_1;
        mux_vch   = fm.ivch_1;
      end
      default: begin
        mux_data  = '0;
        mux_valid = 1'b0;
        mux_vch   = '0;
      end
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg_out
      // Capture every cycle; a select change simply takes effect at the next
      // edge, there is no locking on packet boundaries.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fm.odata  <= '0;
          fm.ovalid <= 1'b0;
          fm.ovch   <= '0;
        end else begin
          fm.odata  <= mux_data;
          fm.ovalid <= mux_valid;
          fm.ovch   <= mux_vch;
        end
      end
    end else begin : g_comb_out
      assign fm.odata  = mux_data;
      assign fm.ovalid = mux_valid;
      assign fm.ovch   = mux_vch;

      // Combinational build has no state, so clock and reset are sunk here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
    end

    if (SEL_W > 2) begin : g_sel_hi
      // Select bits for the other router ports are deliberately ignored.
      logic unused_sel_hi;
      assign unused_sel_hi = ^fm.sel[SEL_W-1:2];
    end
  endgenerate

endmodule

// File: tb/tb_flit_mux.sv
// ---------------------------------------------------------------------------
// tb_flit_mux
// Directed bench for flit_mux with registered outputs (REG_OUT = 1).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_flit_mux;

  localparam int DW = 67;
  localparam int VW = 1;
  localparam int SW = 5;
  localparam int TW = DW + 1 + VW;

  localparam logic [2:0] T_HEAD = 3'd1;
  localparam logic [2:0] T_DATA = 3'd2;
  localparam logic [2:0] T_TAIL = 3'd3;

  logic clk;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  logic [TW-1:0] exp_q[$];

  flit_mux_if #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) bus ();

  flit_mux #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW), .REG_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .fm  (bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need end of test");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_p0(input logic [DW-1:0] d, input logic v, input logic [VW-1:0] c);
    bus.idata_0  = d;
    bus.ivalid_0 = v;
    bus.ivch_0   = c;
  endtask

  task automatic drive_p1(input logic [DW-1:0] d, input logic v, input logic [VW-1:0] c);
    bus.idata_1  = d;
    bus.ivalid_1 = v;
    bus.ivch_1   = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_flit();
    logic [DW-1:0] f;
    f = {$urandom_range(7, 0), $urandom(), $urandom()};
    return f;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] ed, input logic ev,
                       input logic [VW-1:0] ec);
    n_assert++;
    assert ({bus.odata, bus.ovalid, bus.ovch} === {ed, ev, ec})
    else begin
      n_fail++;
      $error("FAIL %s: got data=%h valid=%b vch=%h, need data=%h valid=%b vch=%h",
             tag, bus.odata, bus.ovalid, bus.ovch, ed, ev, ec);
    end
  endtask

  // scoreboard pop: compares the output against the oldest expected tuple
  task automatic check_q(input string tag);
    logic [TW-1:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: got empty expected queue, need an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, e[TW-1:VW+1], e[VW], e[VW-1:0]);
    end
  endtask

  logic [DW-1:0] f_a;
  logic [DW-1:0] f_b;
  logic [DW-1:0] f_cur;
  logic [VW-1:0] vc_cur;
  logic [63:0]   walk;

  initial begin
    rst = 1'b0;
    bus.sel = 5'b00001;
    drive_p0(rnd_flit(), 1'b1, 1'b1);
    drive_p1(rnd_flit(), 1'b1, 1'b0);

    // ---- reset with arbitrary inputs: asynchronous clear, held, released
    #2 rst = 1'b1;
    #1 check("reset_async", '0, 1'b0, '0);
    next_cycle();
    check("reset_held", '0, 1'b0, '0);
    f_a = {T_HEAD, 32'h0, 32'h0000_00aa};
    drive_p0(f_a, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 check("reset_release_no_edge", '0, 1'b0, '0);
    next_cycle();
    check("reset_first_capture", f_a, 1'b1, 1'b1);

    // ---- select port 1
    bus.sel = 5'b00010;
    f_b = {T_HEAD, 32'h0, 32'h0000_0004};
    drive_p1(f_b, 1'b1, 1'b1);
    drive_p0(rnd_flit(), 1'b1, 1'b0);
    next_cycle();
    check("sel_p1_head", f_b, 1'b1, 1'b1);
    drive_p0(rnd_flit(), 1'b1, 1'b1);
    next_cycle();
    check("sel_p1_ignores_p0", f_b, 1'b1, 1'b1);

    // ---- select port 0
    bus.sel = 5'b00001;
    f_a = {T_HEAD, 32'h0, 32'h0000_0009};
    drive_p0(f_a, 1'b1, 1'b0);
    next_cycle();
    check("sel_p0_head_vc0", f_a, 1'b1, 1'b0);
    drive_p0(f_a, 1'b1, 1'b1);
    next_cycle();
    check("sel_p0_head_vc1", f_a, 1'b1, 1'b1);

    // selected invalid flit is forwarded as-is
    f_a = {T_DATA, 64'h1234_5678_9abc_def0};
    drive_p0(f_a, 1'b0, 1'b1);
    next_cycle();
    check("sel_p0_invalid_fwd", f_a, 1'b0, 1'b1);

    // upper select bits are ignored
    f_a = {T_TAIL, 64'h0f0f_0f0f_0f0f_0f0f};
    f_b = {T_DATA, 64'hf0f0_f0f0_f0f0_f0f0};
    drive_p0(f_a, 1'b1, 1'b0);
    drive_p1(f_b, 1'b1, 1'b1);
    bus.sel = 5'b11101;
    next_cycle();
    check("sel_hi_bits_p0", f_a, 1'b1, 1'b0);
    bus.sel = 5'b11110;
    next_cycle();
    check("sel_hi_bits_p1", f_b, 1'b1, 1'b1);

    // ---- illegal selects with both ports valid
    bus.sel = 5'b00000;
    next_cycle();
    check("sel_none", '0, 1'b0, '0);
    bus.sel = 5'b00011;
    next_cycle();
    check("sel_multi", '0, 1'b0, '0);
    bus.sel = 5'b11100;
    next_cycle();
    check("sel_none_hi_set", '0, 1'b0, '0);

    // ---- packet stream on port 1: 10 x (HEAD + 20 DATA + TAIL), 7 idle gaps
    bus.sel = 5'b00010;
    for (int p = 0; p < 10; p++) begin
      vc_cur = VW'(p % 2);
      for (int k = 0; k < 22; k++) begin
        if (k == 0) begin
          f_cur = {T_HEAD, 32'h0, 32'(p)};
        end else if (k == 21) begin
          f_cur = {T_TAIL, 32'hdead_0000 | 32'(p), 32'hffff_ffff};
        end else begin
          walk  = 64'h1 << ((p * 20 + k - 1) % 64);
          f_cur = {T_DATA, walk};
        end
        drive_p1(f_cur, 1'b1, vc_cur);
        drive_p0(rnd_flit(), 1'b1, 1'($urandom_range(1, 0)));
        exp_q.push_back({f_cur, 1'b1, vc_cur});
        next_cycle();
        check_q("stream_flit");
      end
      for (int g = 0; g < 7; g++) begin
        drive_p1('0, 1'b0, '0);
        drive_p0(rnd_flit(), 1'b1, 1'($urandom_range(1, 0)));
        exp_q.push_back({{DW{1'b0}}, 1'b0, {VW{1'b0}}});
        next_cycle();
        check_q("stream_idle");
      end
    end

    // ---- mid-packet reset on port 0
    bus.sel = 5'b00001;
    f_a = {T_HEAD, 32'h0, 32'h0000_0077};
    drive_p0(f_a, 1'b1, 1'b1);
    next_cycle();
    check("mid_head", f_a, 1'b1, 1'b1);
    f_a = {T_DATA, 64'h0000_0000_0001_0000};
    drive_p0(f_a, 1'b1, 1'b1);
    next_cycle();
    check("mid_data", f_a, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 check("mid_reset_async", '0, 1'b0, '0);
    next_cycle();
    check("mid_reset_held", '0, 1'b0, '0);
    #1 rst = 1'b0;
    #1 check("mid_reset_release", '0, 1'b0, '0);

    // ---- sel switch 01 -> 10 between flits
    f_a = {T_DATA, 64'haaaa_aaaa_aaaa_aaaa};
    f_b = {T_HEAD, 32'h0, 32'h0000_0055};
    drive_p0(f_a, 1'b1, 1'b0);
    drive_p1(f_b, 1'b1, 1'b1);
    next_cycle();
    check("switch_before", f_a, 1'b1, 1'b0);
    bus.sel = 5'b00010;
    #1 check("switch_not_yet", f_a, 1'b1, 1'b0);
    next_cycle();
    check("switch_after", f_b, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
